// File: rtl/pipe_dmem_ctrl.sv
// Data-memory controller with byte-enable stores and configurable wait states.
// Optional MMIO window (cycle counter, LED register) under PIPE_DMEM_MMIO_EN.
module pipe_dmem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [15:0]         led_out
);

    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(DEPTH);
    localparam logic [3:0] WS_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     be_q;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              accept, commit, use_q;
    logic              op_we;
    logic [31:0]       op_addr, widx;
    logic [DATA_W-1:0] op_wdata;
    logic [NB-1:0]     op_be;
    logic              ram_hit, mmio_hit;
    logic [DATA_W-1:0] mmio_rd;
    logic [DATA_W-1:0] mem [DEPTH];

    assign req_ready = !rst && (state_q != WAIT);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            WAIT: begin
                if (wait_q == 4'd0) state_d = RESP;
                else                wait_d  = wait_q - 4'd1;
            end
            default: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        wait_d  = WS_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // With zero wait states the op commits on the accept edge, so use live inputs.
    assign commit   = !rst && (state_d == RESP);
    assign use_q    = (state_q == WAIT);
    assign op_we    = use_q ? we_q    : req_we;
    assign op_addr  = use_q ? addr_q  : req_addr;
    assign op_wdata = use_q ? wdata_q : req_wdata;
    assign op_be    = use_q ? be_q    : req_be;

    assign widx    = op_addr >> OFF;
    assign ram_hit = widx < 32'(DEPTH);

`ifdef PIPE_DMEM_MMIO_EN
    logic [31:0] cnt_q, led_q, led_d, wa;
    logic        cnt_sel, led_sel, wide_sel;
    logic [7:0]  be8;
    logic [63:0] wd64;

    assign wa       = op_addr & ~32'(NB - 1);
    assign cnt_sel  = (DATA_W == 32) && (wa == 32'hFFFF_FF00);
    assign led_sel  = (DATA_W == 32) && (wa == 32'hFFFF_FF04);
    assign wide_sel = (DATA_W == 64) && (wa == 32'hFFFF_FF00);
    assign mmio_hit = cnt_sel || led_sel || wide_sel;
    assign be8      = 8'(op_be);
    assign wd64     = 64'(op_wdata);

    assign mmio_rd = DATA_W'(wide_sel ? {led_q, cnt_q} :
                             led_sel  ? {32'b0, led_q} :
                             cnt_sel  ? {32'b0, cnt_q} : 64'b0);

    // 64-bit build keeps the LED register in the upper lane.
    always_comb begin
        led_d = led_q;
        if (commit && op_we) begin
            for (int b = 0; b < 4; b++) begin
                if (led_sel && be8[b])
                    led_d[b*8 +: 8] = wd64[b*8 +: 8];
                if (wide_sel && be8[b+4])
                    led_d[b*8 +: 8] = wd64[32+b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
            led_q <= 32'd0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
            led_q <= led_d;
        end
    end

    assign led_out = led_q[15:0];
`else
    assign mmio_hit = 1'b0;
    assign mmio_rd  = '0;
    assign led_out  = 16'd0;
`endif

    always_comb begin
        err_d   = !(ram_hit || mmio_hit);
        rdata_d = '0;
        if (!err_d && !op_we)
            rdata_d = ram_hit ? mem[widx[IW-1:0]] : mmio_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && op_we && ram_hit) begin
            for (int b = 0; b < NB; b++) begin
                if (op_be[b])
                    mem[widx[IW-1:0]][b*8 +: 8] <= op_wdata[b*8 +: 8];
            end
        end
    end

    assign rsp_valid = !rst && (state_q == RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : '0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: doc/pipe_dmem_ctrl.md
# pipe_dmem_ctrl

Parametrised data-memory controller for the pipelined RV32 SoC, replacing the bare single-cycle data RAM next to the CPU core. It accepts one load/store request at a time over a valid/ready handshake and supports byte-enable writes. Configurable wait states model slower memory so the pipeline's stall logic can be exercised. An optional memory-mapped I/O window provides a cycle counter and an LED register for on-board tests.

## Interface
- `DATA_W`, default 32: data width in bits; multiple of 8, 32 or 64.
- `DEPTH`, default 1024: RAM size in words; power of 2, at least 16.
- `WAIT_STATES`, default 0: extra cycles inserted before each response; legal range 0..15.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: a request is present this cycle.
- `req_ready` out 1: the controller can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address. Word index is `req_addr >> log2(DATA_W/8)`; the low bits are ignored.
- `req_wdata` in `DATA_W`: store data.
- `req_be` in `DATA_W/8`: byte enables for stores; ignored for loads.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out `DATA_W`: load data; 0 for stores and for errors.
- `rsp_err` out 1: the address was out of range; qualified by `rsp_valid`.
- `led_out` out 16: LED register, low 16 bits. Tied to 0 when MMIO is compiled out.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - WAIT: `req_ready`=0. A wait counter counts down from `WAIT_STATES`-1.
  - RESP: `req_ready`=1. `rsp_valid`=1.
- Transitions:
  - Request accepted (`req_valid && req_ready`) in IDLE or RESP: go to WAIT if `WAIT_STATES`>0, else to RESP.
  - WAIT when the counter reaches 0: go to RESP.
  - RESP with no new accept: go to IDLE.
- The accepted request (we, address, wdata, be) is latched at the accept edge. Inputs are don't-care after acceptance.
- Address decode:
  - RAM when the word index < `DEPTH`.
  - MMIO window (when enabled) at 0xFFFF_FF00 and 0xFFFF_FF04 for `DATA_W`=32; the second word of 0xFFFF_FF00 for `DATA_W`=64.
  - Any other address: error.
- Stores:
  - A RAM store writes only the bytes whose `req_be` bit is set.
  - `req_be`=0 is legal; memory is unchanged and the response is normal.
- Errors: an error suppresses the write, forces `rsp_rdata`=0 and sets `rsp_err`=1.
- RAM contents are not cleared by reset and are X until written. An init-file hook is out of scope.

## Timing
- During `rst`: state=IDLE, `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `led_out`=0, cycle counter=0, wait counter=0. `req_ready` rises in the first cycle after `rst` falls.
- Latency: a request accepted at edge T gives `rsp_valid` high during the cycle after edge T+`WAIT_STATES` (edges numbered T, T+1, …).
  - `WAIT_STATES`=0: response in the cycle immediately after the accept edge.
  - `WAIT_STATES`=N: N cycles in WAIT, then 1 cycle in RESP.
- Commit: RAM/MMIO writes commit, and `rsp_rdata` is registered, at the edge entering RESP.
- Throughput:
  - One request per `WAIT_STATES`+1 cycles.
  - `WAIT_STATES`=0 allows back-to-back accepts every cycle.
- Back-to-back hazards: in back-to-back operation, a load that follows a store to the same word returns the newly written data, with no stale read.
- Response path: `rsp_valid` is exactly one cycle per accepted request. There is no response backpressure; the consumer must sample it.
- `rst` during WAIT or RESP:
  - The in-flight request is dropped.
  - A pending write is not committed.
  - No `rsp_valid` is produced.
- `req_valid` while `req_ready`=0 is ignored. The requester must hold the request until it is accepted.

## Configuration
- `PIPE_DMEM_MMIO_EN` defined:
  - 0xFFFF_FF00 is a free-running 32-bit cycle counter. It increments every non-reset cycle and wraps 0xFFFF_FFFF→0. It is read-only; writes are ignored with no error.
  - 0xFFFF_FF04 is a 32-bit LED register. It is read/write and honours `req_be`. `led_out` = its bits [15:0].
- `PIPE_DMEM_MMIO_EN` undefined:
  - Both addresses decode as errors.
  - No counter or LED register logic exists.
  - `led_out` is constant 0.

## Test plan
- Reset, then `WAIT_STATES`=0:
  - Store 0xDEADBEEF to 0x10, then load 0x10 back-to-back → `rsp_rdata`=0xDEADBEEF one cycle after the load accept; `req_ready` stays 1.
- Byte enables:
  - Store 0x11223344 to 0x20 with be=4'b1111.
  - Store 0xAABBCCDD with be=4'b0101.
  - Load → 0x11BB33DD.
- `WAIT_STATES`=3:
  - Load accepted at edge T → `req_ready`=0 for 3 cycles, `rsp_valid` in the 4th cycle after T, exactly one pulse.
- Errors:
  - Store to 4*`DEPTH` → `rsp_err`=1, `rsp_rdata`=0, and RAM word 0 is unchanged (aliasing check).
  - Load 0xFFFF_FF00 with MMIO undefined → `rsp_err`=1.
- MMIO enabled:
  - Write 0x0000_A5A5 to 0xFFFF_FF04 → `led_out`=0xA5A5.
  - Two counter reads 10 cycles apart differ by exactly 10.
- Reset mid-op:
  - `WAIT_STATES`=5, store 0x12345678 to 0x40, assert `rst` in the 2nd wait cycle → no `rsp_valid`.
  - A later load of 0x40 returns its prior value.
